// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-buffer constants and the packed entry layout used by this block and the FIFO->ID stage.
// The packed struct fixes the field order, so both stages agree on the entry layout.
package fetch_buffer_pkg;

    localparam int          FETCH_BUF_DEPTH = 8;
    localparam logic [31:0] INST_NOP        = 32'h0340_0000;
    localparam logic [31:0] PC_RESET        = 32'h1c00_0000;
    localparam logic [31:0] COOKIE_DEFAULT  = 32'd1958;

    typedef struct packed {
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] badv;
        logic [31:0] cookie;
        logic [6:0]  exception;
        logic [1:0]  excp_flag;
        logic [1:0]  ibar_flag;
        logic        cacop_ready;
        logic        cacop_complete;
    } fb_entry_t;

    localparam int FB_ENTRY_W = $bits(fb_entry_t);

    // What the FIFO->ID register sees while the buffer holds nothing.
    function automatic fb_entry_t fb_empty_entry();
        fb_entry_t e;
        e                = '0;
        e.inst0          = INST_NOP;
        e.inst1          = INST_NOP;
        e.pc             = PC_RESET;
        e.pc_next        = PC_RESET + 32'd8;
        e.badv           = PC_RESET;
        e.cookie         = COOKIE_DEFAULT;
        return e;
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// IF-side and ID-side signals of the fetch buffer. Push: if_valid & if_allowin; pop: fifo_readygo & id_allowin.
// slave is the buffer's view; master is the view of the surrounding pipeline.
interface fetch_buffer_if;

    logic        if_valid;
    logic        if_allowin;
    logic [31:0] if_inst0;
    logic [31:0] if_inst1;
    logic [31:0] if_pc;
    logic [31:0] if_pc_next;
    logic [31:0] if_badv;
    logic [31:0] if_cookie;
    logic [6:0]  if_exception;
    logic [1:0]  if_excp_flag;
    logic [1:0]  if_ibar_flag;
    logic        if_cacop_ready;
    logic        if_cacop_complete;

    logic        id_allowin;
    logic        fifo_readygo;
    logic [31:0] fifo_inst0;
    logic [31:0] fifo_inst1;
    logic [31:0] fifo_pc;
    logic [31:0] fifo_pc_next;
    logic [31:0] fifo_pcAdd;
    logic [31:0] fifo_badv;
    logic [31:0] fifo_cookie_out;
    logic [6:0]  fifo_exception;
    logic [1:0]  fifo_excp_flag;
    logic [1:0]  fifo_ibar_flag;
    logic        fifo_cacop_ready;
    logic        fifo_cacop_complete;

    logic        fetch_buf_empty;
    logic        fetch_buf_full;

    modport slave (
        input  if_valid, if_inst0, if_inst1, if_pc, if_pc_next, if_badv, if_cookie,
               if_exception, if_excp_flag, if_ibar_flag, if_cacop_ready, if_cacop_complete,
               id_allowin,
        output if_allowin, fifo_readygo, fifo_inst0, fifo_inst1, fifo_pc, fifo_pc_next,
               fifo_pcAdd, fifo_badv, fifo_cookie_out, fifo_exception, fifo_excp_flag,
               fifo_ibar_flag, fifo_cacop_ready, fifo_cacop_complete,
               fetch_buf_empty, fetch_buf_full
    );

    modport master (
        output if_valid, if_inst0, if_inst1, if_pc, if_pc_next, if_badv, if_cookie,
               if_exception, if_excp_flag, if_ibar_flag, if_cacop_ready, if_cacop_complete,
               id_allowin,
        input  if_allowin, fifo_readygo, fifo_inst0, fifo_inst1, fifo_pc, fifo_pc_next,
               fifo_pcAdd, fifo_badv, fifo_cookie_out, fifo_exception, fifo_excp_flag,
               fifo_ibar_flag, fifo_cacop_ready, fifo_cacop_complete,
               fetch_buf_empty, fetch_buf_full
    );

endinterface

// File: rtl/fetch_buf_ram.sv
// Entry storage for the fetch buffer: one synchronous write port, one combinational read port.
// Deliberately unreset; validity is tracked by the pointer logic in the top.
module fetch_buf_ram #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int W     = 32
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [W-1:0]     rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// Circular instruction fetch buffer between IF and the FIFO->ID register, head presented fall-through.
// Occupancy count (not pointer equality) separates full from empty; flush resets pointers only.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    fetch_buffer_if.slave    bus,
    output logic [PTR_W:0]   dbg_count_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             empty, full, push, pop;
    fb_entry_t        wr_entry, rd_entry, head_entry;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign push  = bus.if_valid & ~full & ~flush;
    assign pop   = ~empty & bus.id_allowin & ~flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        wr_entry                = '0;
        wr_entry.inst0          = bus.if_inst0;
        wr_entry.inst1          = bus.if_inst1;
        wr_entry.pc             = bus.if_pc;
        wr_entry.pc_next        = bus.if_pc_next;
        wr_entry.badv           = bus.if_badv;
        wr_entry.cookie         = bus.if_cookie;
        wr_entry.exception      = bus.if_exception;
        wr_entry.excp_flag      = bus.if_excp_flag;
        wr_entry.ibar_flag      = bus.if_ibar_flag;
        wr_entry.cacop_ready    = bus.if_cacop_ready;
        wr_entry.cacop_complete = bus.if_cacop_complete;
    end

    fetch_buf_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (FB_ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (tail_q),
        .wdata_i (wr_entry),
        .raddr_i (head_q),
        .rdata_o (rd_entry)
    );

    // Stale RAM contents after a flush are masked here by the empty defaults.
    assign head_entry = empty ? fb_empty_entry() : rd_entry;

    assign bus.fifo_inst0          = head_entry.inst0;
    assign bus.fifo_inst1          = head_entry.inst1;
    assign bus.fifo_pc             = head_entry.pc;
    assign bus.fifo_pc_next        = head_entry.pc_next;
    assign bus.fifo_pcAdd          = head_entry.pc + 32'd4;
    assign bus.fifo_badv           = head_entry.badv;
    assign bus.fifo_cookie_out     = head_entry.cookie;
    assign bus.fifo_exception      = head_entry.exception;
    assign bus.fifo_excp_flag      = head_entry.excp_flag;
    assign bus.fifo_ibar_flag      = head_entry.ibar_flag;
    assign bus.fifo_cacop_ready    = head_entry.cacop_ready;
    assign bus.fifo_cacop_complete = head_entry.cacop_complete;

    assign bus.fetch_buf_empty = empty;
    assign bus.fetch_buf_full  = full;
    assign bus.if_allowin      = ~full;
    assign bus.fifo_readygo    = ~empty;
    assign dbg_count_o         = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: driver pushes expected entries into a queue, a monitor pops on each dequeue.
// Status outputs are checked every cycle against a bench-side occupancy count.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int W = FB_ENTRY_W;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic [3:0] dbg_count;

    fetch_buffer_if bus ();

    fetch_buffer #(.DEPTH(8), .PTR_W(3)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .bus         (bus),
        .dbg_count_o (dbg_count)
    );

    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           mcount = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic fb_entry_t mk(input logic [31:0] pc);
        fb_entry_t p;
        p         = '0;
        p.inst0   = pc ^ 32'ha5a5_0000;
        p.inst1   = pc ^ 32'h5a5a_0000;
        p.pc      = pc;
        p.pc_next = pc + 32'd8;
        p.badv    = pc + 32'd1;
        p.cookie  = pc + 32'h100;
        return p;
    endfunction

    function automatic fb_entry_t head_of();
        fb_entry_t e;
        e.inst0          = bus.fifo_inst0;
        e.inst1          = bus.fifo_inst1;
        e.pc             = bus.fifo_pc;
        e.pc_next        = bus.fifo_pc_next;
        e.badv           = bus.fifo_badv;
        e.cookie         = bus.fifo_cookie_out;
        e.exception      = bus.fifo_exception;
        e.excp_flag      = bus.fifo_excp_flag;
        e.ibar_flag      = bus.fifo_ibar_flag;
        e.cacop_ready    = bus.fifo_cacop_ready;
        e.cacop_complete = bus.fifo_cacop_complete;
        return e;
    endfunction

    task automatic drive(input logic v, input fb_entry_t p, input logic allow, input logic fl);
        bus.if_valid          = v;
        bus.if_inst0          = p.inst0;
        bus.if_inst1          = p.inst1;
        bus.if_pc             = p.pc;
        bus.if_pc_next        = p.pc_next;
        bus.if_badv           = p.badv;
        bus.if_cookie         = p.cookie;
        bus.if_exception      = p.exception;
        bus.if_excp_flag      = p.excp_flag;
        bus.if_ibar_flag      = p.ibar_flag;
        bus.if_cacop_ready    = p.cacop_ready;
        bus.if_cacop_complete = p.cacop_complete;
        bus.id_allowin        = allow;
        flush                 = fl;
    endtask

    // One clock of stimulus; the bench's own occupancy count decides what is accepted.
    task automatic cycle(input logic v, input fb_entry_t p, input logic allow, input logic fl);
        logic do_push, do_pop;
        drive(v, p, allow, fl);
        do_push = v && (mcount < 8) && !fl;
        do_pop  = (mcount > 0) && allow && !fl;
        @(negedge clk);
        chk("if_allowin", bus.if_allowin, (mcount < 8));
        chk("fifo_readygo", bus.fifo_readygo, (mcount > 0));
        chk("count", dbg_count, mcount[3:0]);
        if (do_push) exp_q.push_back(p);
        @(posedge clk);
        if (fl) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            mcount = mcount + int'(do_push) - int'(do_pop);
        end
        #1;
    endtask

    task automatic check_defaults(input string tag);
        chk({tag, "_empty"}, bus.fetch_buf_empty, 1'b1);
        chk({tag, "_full"}, bus.fetch_buf_full, 1'b0);
        chk({tag, "_readygo"}, bus.fifo_readygo, 1'b0);
        chk({tag, "_allowin"}, bus.if_allowin, 1'b1);
        chk({tag, "_head"}, head_of(), fb_empty_entry());
        chk({tag, "_inst0"}, bus.fifo_inst0, INST_NOP);
        chk({tag, "_pc"}, bus.fifo_pc, PC_RESET);
        chk({tag, "_pcAdd"}, bus.fifo_pcAdd, PC_RESET + 32'd4);
        chk({tag, "_pc_next"}, bus.fifo_pc_next, PC_RESET + 32'd8);
        chk({tag, "_cookie"}, bus.fifo_cookie_out, 32'd1958);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && mcount > 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Monitor: compares the head against the scoreboard on every dequeue handshake.
    always @(negedge clk) begin
        fb_entry_t e;
        if (rstn && bus.fifo_readygo && bus.id_allowin && !flush) begin
            if (exp_q.size() == 0) begin
                chk("pop_with_empty_scoreboard", 1'b1, 1'b0);
            end else begin
                e = fb_entry_t'(exp_q.pop_front());
                chk("head_entry", head_of(), e);
                chk("head_pcAdd", bus.fifo_pcAdd, e.pc + 32'd4);
            end
        end
        if (rstn && bus.fetch_buf_full) chk("no_push_when_full", bus.if_allowin, 1'b0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fb_entry_t sp;
        rstn = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_defaults("reset");
        rstn = 1'b1;

        // 1: idle with id_allowin high
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check_defaults("idle");

        // 2: fill with the ID side stalled; the ninth packet must be refused
        for (int k = 0; k < 8; k++) cycle(1'b1, mk(32'h1c00_0000 + 32'(8 * k)), 1'b0, 1'b0);
        chk("full_after_8", bus.fetch_buf_full, 1'b1);
        chk("allowin_after_8", bus.if_allowin, 1'b0);
        cycle(1'b1, mk(32'h1c00_0040), 1'b0, 1'b0);
        chk("head_pc_after_9th", bus.fifo_pc, 32'h1c00_0000);
        chk("count_after_9th", dbg_count, 4'd8);

        // 3: drain all eight in order
        for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        check_defaults("drained");

        // 4: steady push+pop at occupancy 3, pointers wrap several times
        for (int k = 0; k < 3; k++) cycle(1'b1, mk(32'h1c10_0000 + 32'(8 * k)), 1'b0, 1'b0);
        for (int k = 3; k < 23; k++) cycle(1'b1, mk(32'h1c10_0000 + 32'(8 * k)), 1'b1, 1'b0);
        chk("count_steady", dbg_count, 4'd3);
        drain();
        check_defaults("after_steady");

        // 5: flush at occupancy 5 with push and pop requested
        for (int k = 0; k < 5; k++) cycle(1'b1, mk(32'h1c20_0000 + 32'(8 * k)), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h1c20_0100), 1'b1, 1'b1);
        check_defaults("after_flush");
        chk("count_after_flush", dbg_count, 4'd0);
        cycle(1'b1, mk(32'h1c30_0000), 1'b0, 1'b0);
        chk("head_after_flush_push", head_of(), mk(32'h1c30_0000));
        drain();

        // 6: side fields pass through, then async reset mid-stream
        sp                = mk(32'h1c40_0000);
        sp.exception      = 7'h08;
        sp.excp_flag      = 2'b01;
        sp.ibar_flag      = 2'b10;
        sp.cacop_ready    = 1'b1;
        cycle(1'b1, sp, 1'b0, 1'b0);
        chk("side_fields_head", head_of(), sp);
        chk("side_exception", bus.fifo_exception, 7'h08);
        chk("side_excp_flag", bus.fifo_excp_flag, 2'b01);
        chk("side_ibar_flag", bus.fifo_ibar_flag, 2'b10);
        chk("side_cacop_ready", bus.fifo_cacop_ready, 1'b1);
        cycle(1'b1, mk(32'h1c40_0008), 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        mcount = 0;
        exp_q.delete();
        chk("async_reset_count", dbg_count, 4'd0);
        check_defaults("async_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_defaults("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
